hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage processor. It works alongside the forwarding logic and covers the cases forwarding cannot resolve.
- Detects load-use and flag-use hazards and sequences taken-branch flushes.
- Holds the pipeline while a data-memory access is outstanding, using a req/ack handshake.
- Drives PC/IF-ID write enables, the ID/EX bubble insert, the IF/ID flush, and a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard / stall sequencer for the 5-stage core.
// Catches load-use and flag-use hazards that forwarding cannot cover,
// sequences IF/ID flushes after taken branches, and freezes the whole
// pipeline while a data-memory access is outstanding (req/ack).
// State is registered; the control outputs are decoded combinationally
// from state plus the current inputs so they act in the same cycle.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // 1..3
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IdEx_MemRead,
    input  logic [4:0]       IdEx_Rd,
    input  logic [4:0]       IfId_Rn,
    input  logic [4:0]       IfId_Rm,
    input  logic             IfId_usesRm,
    input  logic             flagSetEX,
    input  logic             IfId_condBr,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [1:0] FC_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] fcnt, fcnt_nxt;   // remaining flush cycles; nonzero only while a flush is pending
    logic       lu_haz, fl_haz, mem_stall;

    // X31 is the zero register, so it never carries a real dependency.
    assign lu_haz = IdEx_MemRead && (IdEx_Rd != 5'd31) &&
                    ((IdEx_Rd == IfId_Rn) || (IfId_usesRm && (IdEx_Rd == IfId_Rm)));
    // ALU flags are forwarded; only a flag-setting load needs the stall.
    assign fl_haz = flagSetEX && IfId_condBr && IdEx_MemRead;
    // A req acked in the same cycle costs nothing.
    assign mem_stall = dmem_req && !dmem_ack;

    // Next-state and output decode; reset forces the free-running defaults.
    always_comb begin
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pipe_hold   = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        pipe_hold  = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        state_nxt  = MEM_WAIT;
                    end else if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt = FLUSH;
                            fcnt_nxt  = FC_RELOAD;
                        end
                    end else if (lu_haz || fl_haz) begin
                        // The bubble clears IdEx_MemRead, so this lasts one cycle.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Branches/hazards are ignored here; upstream is frozen and holds them.
                    if (dmem_ack) begin
                        // Resume an interrupted flush if one was pending.
                        state_nxt = (fcnt != 2'd0) ? FLUSH : RUN;
                    end else begin
                        pipe_hold  = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end
                end
                FLUSH: begin
                    if (mem_stall) begin
                        // Counter is preserved across the memory wait.
                        pipe_hold  = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        state_nxt  = MEM_WAIT;
                    end else begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (branch_taken) begin
                            fcnt_nxt = FC_RELOAD;
                        end else if (fcnt <= 2'd1) begin
                            fcnt_nxt  = 2'd0;
                            state_nxt = RUN;
                        end else begin
                            fcnt_nxt = fcnt - 2'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                    fcnt_nxt  = 2'd0;
                end
            endcase
        end
    end

    // State and flush-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Saturating count of cycles spent holding, bubbling or flushing.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if ((pipe_hold || idex_bubble || ifid_flush) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (FLUSH_CYCLES=2, CNT_W=16).
// Inputs change just after a rising edge; outputs are checked 1ns later,
// well before the next edge. Output vector = {pc_write, ifid_write,
// idex_bubble, ifid_flush, pipe_hold}.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        IdEx_MemRead;
    logic [4:0]  IdEx_Rd, IfId_Rn, IfId_Rm;
    logic        IfId_usesRm, flagSetEX, IfId_condBr, branch_taken;
    logic        dmem_req, dmem_ack;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] O_RUN  = 5'b11000;
    localparam logic [4:0] O_LU   = 5'b00100;
    localparam logic [4:0] O_HOLD = 5'b00001;
    localparam logic [4:0] O_FL   = 5'b11110;

    hazard_stall_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .IdEx_MemRead(IdEx_MemRead), .IdEx_Rd(IdEx_Rd),
        .IfId_Rn(IfId_Rn), .IfId_Rm(IfId_Rm), .IfId_usesRm(IfId_usesRm),
        .flagSetEX(flagSetEX), .IfId_condBr(IfId_condBr),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .pipe_hold(pipe_hold), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_o(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {27'd0, pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold}, {27'd0, exp});
    endtask

    task automatic clr();
        IdEx_MemRead = 0; IdEx_Rd = 0; IfId_Rn = 0; IfId_Rm = 0;
        IfId_usesRm = 0; flagSetEX = 0; IfId_condBr = 0;
        branch_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    initial begin
        clr();
        reset = 1;
        tick(); tick();
        chk_o("rst_outs", O_RUN);
        chk("rst_cnt", 32'(stall_cycles), 32'd0);
        // reset overrides any stimulus
        dmem_req = 1; IdEx_MemRead = 1; IdEx_Rd = 5; IfId_Rn = 5;
        chk_o("rst_gate", O_RUN);
        tick();
        clr(); reset = 0;

        // 1. load-use on Rn
        IdEx_MemRead = 1; IdEx_Rd = 5; IfId_Rn = 5;
        chk_o("lu_rn", O_LU);
        tick(); IdEx_MemRead = 0;
        chk_o("lu_clear", O_RUN);
        chk("lu_cnt", 32'(stall_cycles), 32'd1);
        // load-use on Rm
        IdEx_MemRead = 1; IdEx_Rd = 7; IfId_Rm = 7; IfId_usesRm = 1;
        chk_o("lu_rm", O_LU);
        tick(); clr();
        chk("lu_rm_cnt", 32'(stall_cycles), 32'd2);

        // 2. X31 and unused Rm
        IdEx_MemRead = 1; IdEx_Rd = 31; IfId_Rn = 31;
        chk_o("x31", O_RUN);
        tick();
        IdEx_Rd = 7; IfId_Rn = 0; IfId_Rm = 7; IfId_usesRm = 0;
        chk_o("rm_unused", O_RUN);
        tick(); clr();
        chk("nohaz_cnt", 32'(stall_cycles), 32'd2);
        // flag-use hazard (needs a load in EX)
        flagSetEX = 1; IfId_condBr = 1;
        chk_o("fl_noload", O_RUN);
        IdEx_MemRead = 1; IdEx_Rd = 31;
        chk_o("fl_haz", O_LU);
        tick(); clr();
        chk("fl_cnt", 32'(stall_cycles), 32'd3);

        // 3. memory wait: req cycle + 3 wait cycles, ack in 5th cycle
        dmem_req = 1;
        chk_o("mw_req", O_HOLD);
        tick(); dmem_req = 0;
        chk_o("mw_w1", O_HOLD);
        tick(); branch_taken = 1; IdEx_MemRead = 1; IdEx_Rd = 5; IfId_Rn = 5;
        chk_o("mw_ign", O_HOLD);
        tick(); clr();
        chk_o("mw_w3", O_HOLD);
        tick(); dmem_ack = 1;
        chk_o("mw_ack", O_RUN);
        tick(); dmem_ack = 0;
        chk_o("mw_after", O_RUN);
        chk("mw_cnt", 32'(stall_cycles), 32'd7);
        dmem_req = 1; dmem_ack = 1;
        chk_o("mw_zero", O_RUN);
        tick(); clr();
        chk_o("mw_zero2", O_RUN);
        chk("mw_zero_cnt", 32'(stall_cycles), 32'd7);

        // 4. branch flush, 2 cycles
        branch_taken = 1;
        chk_o("br_c0", O_FL);
        tick(); branch_taken = 0;
        chk_o("br_c1", O_FL);
        tick();
        chk_o("br_done", O_RUN);
        chk("br_cnt", 32'(stall_cycles), 32'd9);
        branch_taken = 1;
        chk_o("br2_c0", O_FL);
        tick();
        chk_o("br2_c1_reload", O_FL);
        tick(); branch_taken = 0;
        chk_o("br2_c2", O_FL);
        tick();
        chk_o("br2_done", O_RUN);
        chk("br2_cnt", 32'(stall_cycles), 32'd12);

        // 5. branch beats load-use; dmem_req interrupts flush
        branch_taken = 1; IdEx_MemRead = 1; IdEx_Rd = 5; IfId_Rn = 5;
        chk_o("pri_br_lu", O_FL);
        tick(); clr(); dmem_req = 1;
        chk_o("pri_req_in_fl", O_HOLD);
        tick(); dmem_req = 0;
        chk_o("pri_wait", O_HOLD);
        tick(); dmem_ack = 1;
        chk_o("pri_ack", O_RUN);
        tick(); dmem_ack = 0;
        chk_o("pri_resume_fl", O_FL);
        tick();
        chk_o("pri_done", O_RUN);
        chk("pri_cnt", 32'(stall_cycles), 32'd16);

        // 6. reset mid MEM_WAIT, pending ack ignored
        dmem_req = 1;
        tick(); dmem_req = 0;
        chk_o("rw_wait", O_HOLD);
        tick(); reset = 1; dmem_ack = 1;
        chk_o("rw_in_rst", O_RUN);
        tick(); reset = 0;
        chk_o("rw_run", O_RUN);
        chk("rw_cnt", 32'(stall_cycles), 32'd0);
        tick(); dmem_ack = 0;
        chk_o("rw_run2", O_RUN);

        // saturation: long memory wait
        dmem_req = 1;
        tick(); dmem_req = 0;
        for (int i = 0; i < 65540; i++) tick();
        chk_o("sat_hold", O_HOLD);
        chk("sat_cnt", 32'(stall_cycles), 32'h0000FFFF);
        dmem_ack = 1;
        tick(); dmem_ack = 0;
        chk_o("sat_run", O_RUN);
        chk("sat_cnt2", 32'(stall_cycles), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
